demux_rr_scheduler: RTL and testbench
=====================================

// Module: demux_rr_scheduler
// PURPOSE
//  Sequencer that shares one 1-to-N demultiplexer between one input stream and N_CH consumer channels.
//  Holds one word and binds it to a channel:
//   - mode=0: round-robin over enabled channels.
//   - mode=1: fixed channel cfg_sel.
//  Drives the demux select and a one-hot valid towards the consumers. Sits between a single producer and the demux-based fan-out.
//  Sticky stall error when a consumer blocks too long.
// PARAMETERS
//  N_CH      4    number of output channels (power of 2, >=2)
//  SEL_W     2    select width, = log2(N_CH)
//  W         8    data width
//  STALL_MAX 15   stall cycles on one channel before err_stall sets (>=1)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      producer has a word
//  in_data    in   W      producer word
//  in_ready   out  1      word accepted when in_valid & in_ready
//  mode       in   1      0 = round-robin, 1 = fixed channel
//  cfg_sel    in   SEL_W  target channel in fixed mode
//  ch_en      in   N_CH   per-channel enable mask
//  out_valid  out  N_CH   one-hot; bit sel = buf_valid
//  out_data   out  W      shared data bus (held word)
//  out_ready  in   N_CH   per-channel consumer ready
//  sel        out  SEL_W  demux select of the bound channel
//  err_stall  out  1      sticky; set when stall_cnt reaches STALL_MAX
// BEHAVIOUR
//  Reset values: state=IDLE, buf_valid=0, out_data=0, sel=0, ptr=0, stall_cnt=0, err_stall=0, out_valid=0.
//  Fire condition: fire = buf_valid & out_ready[sel].
//  Target availability:
//   - avail = |ch_en (mode 0), ch_en[cfg_sel] (mode 1).
//   - in_ready = avail & (state==IDLE | fire); combinational, no dependency on in_valid.
//  Capture (in_valid & in_ready):
//   - out_data <= in_data, buf_valid <= 1.
//   - sel <= first enabled channel at or after ptr_next, circular (mode 0); cfg_sel (mode 1).
//   - ptr_next = fire ? sel+1 mod N_CH : ptr; ptr <= ptr_next every cycle.
//  Throughput and latency:
//   - Back-to-back capture in the fire cycle gives one word/cycle throughput.
//   - Latency: in_data to out_data/out_valid is 1 cycle.
//  FSM:
//   - IDLE -> HOLD on capture.
//   - HOLD -> IDLE on fire without capture; HOLD -> HOLD on fire with capture.
//   - HOLD -> STALL when stall_cnt == STALL_MAX-1 and no fire.
//   - STALL -> IDLE/HOLD on fire, same rules as HOLD.
//  stall_cnt:
//   - Increments each HOLD/STALL cycle without fire; saturates at STALL_MAX.
//   - Clears on fire.
//   - err_stall <= 1 when stall_cnt reaches STALL_MAX; cleared only by rst.
//  Binding is final: a held word is never rerouted.
//   - ch_en[sel] or mode/cfg_sel changes while held do not move it; it waits for out_ready[sel].
//   - mode, cfg_sel and ch_en are sampled only at capture.
//  Corner cases:
//   - ch_en all-zero (mode 0) or ch_en[cfg_sel]=0 (mode 1): in_ready=0; a held word still drains.
//   - Wrap-around: ptr and sel wrap N_CH-1 -> 0; disabled channels are skipped.
//   - Single enabled channel: every word goes to it.
//  out_data and sel are stable while buf_valid & !fire.
//  Reset mid-operation: the held word is discarded; all outputs return to reset values next cycle.
// STRUCTURE
//  Include file demux_sched_defs.vh holds:
//   - state encodings ST_IDLE=2'd0, ST_HOLD=2'd1, ST_STALL=2'd2.
//   - MODE_RR=1'b0, MODE_FIXED=1'b1.
//  Sub-module demux_1xn: combinational, parameterised on N_CH/SEL_W; (I=buf_valid, sel) -> one-hot out_valid.
//  Priority search "first enabled at/after ptr" is a function inside this module.
// TESTING
//  T1 reset: assert rst 2 cycles mid-HOLD -> all outputs 0, in_ready=1 next cycle with ch_en=4'hF.
//  T2 round-robin: ch_en=F, all ready, 8 words back-to-back -> sel 0,1,2,3,0,1,2,3; 1 word/cycle.
//  T3 skip: ch_en=4'b1010, all ready, 4 words -> sel 1,3,1,3; out_valid 0010,1000,0010,1000.
//  T4 fixed: mode=1, cfg_sel=2; change cfg_sel to 0 while word held -> held word exits on ch 2, next on ch 0.
//  T5 stall: out_ready=0 for 20 cycles with word on ch 1 -> err_stall=1 after 15 cycles, data held.
//     Then out_ready[1]=1 -> fire, stall_cnt=0, err_stall stays 1.
//  T6 none enabled: ch_en=0 -> in_ready=0, out_valid=0 for 10 cycles.
//     Then set ch_en=4'b0100 -> next word on ch 2.

Source files
------------

// File: rtl/demux_rr_scheduler_pkg.sv
// demux_rr_scheduler_pkg: shared state and mode encodings for the demux scheduler
package demux_rr_scheduler_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_STALL = 2'd2} state_t;
  localparam logic MODE_RR = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
endpackage

// File: rtl/demux_1xn.sv
// demux_1xn: steers a single valid onto one of N_CH one-hot lines
module demux_1xn #(
  parameter int N_CH = 4,
  parameter int SEL_W = 2
) (
  input  logic             i,
  input  logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  o
);
  always_comb o = i ? (N_CH'(1) << sel) : '0;
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: binds one held word to a channel (round-robin or fixed) and drives the shared demux
module demux_rr_scheduler
  import demux_rr_scheduler_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SEL_W = 2,
  parameter int W = 8,
  parameter int STALL_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  out_valid,
  output logic [W-1:0]     out_data,
  input  logic [N_CH-1:0]  out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             err_stall
);
  localparam int CNT_W = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STALL_MAX);
  state_t state_q;
  logic buf_valid_q, err_q, fire, avail, cap;
  logic [W-1:0] data_q;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d;
  logic [CNT_W-1:0] stall_q;
  // lowest circular offset from p wins, so scan offsets high to low
  function automatic logic [SEL_W-1:0] first_en(input logic [N_CH-1:0] en, input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] k;
    first_en = p;
    for (int i = N_CH - 1; i >= 0; i--) begin
      k = p + SEL_W'(i);
      if (en[k]) first_en = k;
    end
  endfunction
  always_comb begin
    fire = buf_valid_q & out_ready[sel_q];
    avail = (mode == MODE_FIXED) ? ch_en[cfg_sel] : |ch_en;
    in_ready = avail & ((state_q == ST_IDLE) | fire);
    cap = in_valid & in_ready;
    ptr_d = fire ? sel_q + 1'b1 : ptr_q;
    sel_d = (mode == MODE_RR) ? first_en(ch_en, ptr_d) : cfg_sel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_valid_q <= 1'b0;
      data_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      stall_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (cap) begin
        data_q <= in_data;
        sel_q <= sel_d;
      end
      buf_valid_q <= cap | (buf_valid_q & ~fire);
      stall_q <= fire ? '0 : ((state_q != ST_IDLE) && (stall_q != SMAX)) ? stall_q + 1'b1 : stall_q;
      err_q <= err_q | (stall_q == SMAX);
      case (state_q)
        ST_IDLE: if (cap) state_q <= ST_HOLD;
        ST_HOLD, ST_STALL:
          if (fire) state_q <= cap ? ST_HOLD : ST_IDLE;
          else if ((state_q == ST_HOLD) && (stall_q == SMAX - 1'b1)) state_q <= ST_STALL;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  demux_1xn #(.N_CH(N_CH), .SEL_W(SEL_W)) u_demux (.i(buf_valid_q), .sel(sel_q), .o(out_valid));
  assign out_data = data_q;
  assign sel = sel_q;
  assign err_stall = err_q;
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler: directed vectors with hand-computed expectations for demux_rr_scheduler
module tb_demux_rr_scheduler;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, mode, err_stall;
  logic [7:0] in_data, out_data;
  logic [1:0] cfg_sel, sel;
  logic [3:0] ch_en, out_valid, out_ready;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  demux_rr_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .cfg_sel(cfg_sel), .ch_en(ch_en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sel(sel), .err_stall(err_stall)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [1:0] t2_sel [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [1:0] t3_sel [4] = '{1, 3, 1, 3};
  logic [3:0] t3_ov [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; cfg_sel = '0;
    ch_en = 4'hF; out_ready = 4'hF;
    tick(); tick();
    // T1: reset while a word is held
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 4'h0;
    tick();
    chk("t1_hold_ov", 32'(out_valid), 32'h1);
    chk("t1_hold_data", 32'(out_data), 32'hA5);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("t1_rst_ov", 32'(out_valid), 0);
    chk("t1_rst_data", 32'(out_data), 0);
    chk("t1_rst_sel", 32'(sel), 0);
    chk("t1_rst_err", 32'(err_stall), 0);
    rst = 1'b0; out_ready = 4'hF;
    #1;
    chk("t1_in_ready", 32'(in_ready), 1);
    // T2: round-robin, all enabled, back-to-back
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h10 + i);
      tick();
      chk("t2_sel", 32'(sel), 32'(t2_sel[i]));
      chk("t2_ov", 32'(out_valid), 32'(4'b0001 << t2_sel[i]));
      chk("t2_data", 32'(out_data), 32'(8'h10 + i));
      chk("t2_in_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("t2_drain_ov", 32'(out_valid), 0);
    // T3: disabled channels skipped
    ch_en = 4'b1010; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h30 + i);
      tick();
      chk("t3_sel", 32'(sel), 32'(t3_sel[i]));
      chk("t3_ov", 32'(out_valid), 32'(t3_ov[i]));
    end
    in_valid = 1'b0;
    tick();
    chk("t3_drain_ov", 32'(out_valid), 0);
    // T4: fixed mode, binding survives a cfg_sel change
    ch_en = 4'hF; mode = 1'b1; cfg_sel = 2'd2; out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h44;
    tick();
    chk("t4_sel", 32'(sel), 2);
    chk("t4_ov", 32'(out_valid), 32'h4);
    in_valid = 1'b0; cfg_sel = 2'd0;
    tick();
    chk("t4_held_sel", 32'(sel), 2);
    chk("t4_held_data", 32'(out_data), 32'h44);
    chk("t4_held_in_ready", 32'(in_ready), 0);
    out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("t4_fire_in_ready", 32'(in_ready), 1);
    tick();
    chk("t4_next_sel", 32'(sel), 0);
    chk("t4_next_ov", 32'(out_valid), 32'h1);
    chk("t4_next_data", 32'(out_data), 32'h55);
    in_valid = 1'b0;
    tick();
    chk("t4_drain_ov", 32'(out_valid), 0);
    // T5: stall on channel 1 (ptr is 1 after T4 drained channel 0)
    mode = 1'b0; out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    chk("t5_sel", 32'(sel), 1);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_err_early", 32'(err_stall), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_err_set", 32'(err_stall), 1);
    chk("t5_data_held", 32'(out_data), 32'h77);
    chk("t5_ov_held", 32'(out_valid), 32'h2);
    out_ready = 4'b0010;
    tick();
    chk("t5_fire_ov", 32'(out_valid), 0);
    chk("t5_err_sticky", 32'(err_stall), 1);
    // T6: nothing enabled, then only channel 2
    ch_en = 4'h0; out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_in_ready", 32'(in_ready), 0);
      chk("t6_ov", 32'(out_valid), 0);
    end
    ch_en = 4'b0100;
    #1;
    chk("t6_en_in_ready", 32'(in_ready), 1);
    tick();
    chk("t6_sel", 32'(sel), 2);
    chk("t6_ov_ch2", 32'(out_valid), 32'h4);
    chk("t6_data", 32'(out_data), 32'h99);
    in_valid = 1'b0;
    tick();
    chk("t6_drain_ov", 32'(out_valid), 0);
    chk("t6_err_sticky", 32'(err_stall), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
